// File: rtl/uart_rx_mm_pkg.sv
// uart_rx_mm_pkg: shared addresses, FSM state encodings and status-word layout
// for the memory-mapped UART receiver.
`default_nettype none

package uart_rx_mm_pkg;

    localparam logic [31:0] UART_RX_ADDR      = 32'h1000_0010;
    localparam logic [31:0] UART_RX_STAT_ADDR = 32'h1000_0014;

    localparam int          STATE_W   = 3;
    localparam logic [2:0]  ST_IDLE   = 3'd0;
    localparam logic [2:0]  ST_START  = 3'd1;
    localparam logic [2:0]  ST_DATA   = 3'd2;
    localparam logic [2:0]  ST_PARITY = 3'd3;
    localparam logic [2:0]  ST_STOP   = 3'd4;

    localparam int STAT_VALID_BIT   = 0;
    localparam int STAT_OVERRUN_BIT = 1;
    localparam int STAT_FRAME_BIT   = 2;
    localparam int STAT_PARITY_BIT  = 3;
    localparam int STAT_COUNT_LSB   = 8;
    localparam int STAT_COUNT_MSB   = 16;

    // Assembles the word returned by a load from UART_RX_STAT_ADDR.
    function automatic logic [31:0] pack_status(
        input logic       valid,
        input logic       overrun,
        input logic       frame,
        input logic       parity,
        input logic [8:0] count
    );
        logic [31:0] s;
        s = '0;
        s[STAT_VALID_BIT]                  = valid;
        s[STAT_OVERRUN_BIT]                = overrun;
        s[STAT_FRAME_BIT]                  = frame;
        s[STAT_PARITY_BIT]                 = parity;
        s[STAT_COUNT_MSB:STAT_COUNT_LSB]   = count;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through synchronous FIFO; a push into a full
// FIFO is accepted only when a pop frees the slot in the same cycle.
`default_nettype none

module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_mm.sv
// uart_rx_mm: memory-mapped UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN
// is defined) with a FWFT receive FIFO and sticky error flags.
`default_nettype none

module uart_rx_mm
    import uart_rx_mm_pkg::*;
#(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       sysclk,
    input  logic       nrst,
    input  logic       uart_rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rx_valid,
    output logic [8:0] rx_count,
    output logic       overrun_err,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    input  logic       err_clr
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic                sync1_q, sync2_q, prev_q;
    logic [STATE_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0]    baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                push_q, push_d;
    logic [7:0]          push_byte_q, push_byte_d;
    logic                frame_err_q, overrun_err_q;
    logic                frame_set, par_ok;
    logic                fall, tick;

    logic [7:0]                    fifo_head;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          fifo_full, fifo_empty;

`ifdef UART_RX_PARITY_EN
    logic par_ok_q, par_ok_d, parity_set, parity_err_q;
    assign par_ok = par_ok_q;
`else
    assign par_ok = 1'b1;
`endif

    assign fall = prev_q & ~sync2_q;
    assign tick = (baud_q == '0);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_byte_d = push_byte_q;
        frame_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d    = par_ok_q;
        parity_set  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    baud_d  = HALF_RELOAD;
                end
            end
            ST_START: begin
                if (!tick) begin
                    baud_d = baud_q - CNT_W'(1);
                end else if (sync2_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                    baud_d  = BIT_RELOAD;
                    bit_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
                    par_ok_d = 1'b1;
`endif
                end
            end
            ST_DATA: begin
                if (!tick) begin
                    baud_d = baud_q - CNT_W'(1);
                end else begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    baud_d  = BIT_RELOAD;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!tick) begin
                    baud_d = baud_q - CNT_W'(1);
                end else begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    if (^{shift_q, sync2_q}) begin
                        par_ok_d   = 1'b0;
                        parity_set = 1'b1;
                    end
                    state_d = ST_STOP;
                    baud_d  = BIT_RELOAD;
                end
            end
`endif
            ST_STOP: begin
                if (!tick) begin
                    baud_d = baud_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    if (!sync2_q) begin
                        frame_set = 1'b1;
                    end else if (par_ok) begin
                        push_d      = 1'b1;
                        push_byte_d = shift_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
            state_q       <= ST_IDLE;
            baud_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            push_q        <= 1'b0;
            push_byte_q   <= '0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            sync1_q       <= uart_rx;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            push_q        <= push_d;
            push_byte_q   <= push_byte_d;
            // A new error event in the same cycle as err_clr keeps the flag set.
            frame_err_q   <= frame_set | (frame_err_q & ~err_clr);
            overrun_err_q <= (push_q & fifo_full & ~rd_en) | (overrun_err_q & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            par_ok_q     <= 1'b1;
            parity_err_q <= 1'b0;
        end else begin
            par_ok_q     <= par_ok_d;
            parity_err_q <= parity_set | (parity_err_q & ~err_clr);
        end
    end
    assign parity_err = parity_err_q;
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (sysclk),
        .rst_n     (nrst),
        .push      (push_q),
        .push_data (push_byte_q),
        .pop       (rd_en),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_data     = fifo_empty ? 8'h00 : fifo_head;
    assign rx_valid    = ~fifo_empty;
    assign rx_count    = 9'(fifo_count);
    assign overrun_err = overrun_err_q;
    assign frame_err   = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_mm.sv
// tb_uart_rx_mm: directed frames into uart_rx_mm; popped bytes are checked
// against an expected-byte queue by a separate monitor process.
`default_nettype none

module tb_uart_rx_mm;

    localparam int CLK_FREQ   = 1600000;
    localparam int BAUD_RATE  = 100000;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Clock edge (counted from the start-bit drive) whose following cycle holds the push.
    localparam int PUSH_EDGE = 11 + CPB * (FRAME_BITS - 1);

    logic       sysclk = 1'b0;
    logic       nrst, uart_rx, rd_en, err_clr;
    logic [7:0] rd_data;
    logic       rx_valid, overrun_err, frame_err;
    logic [8:0] rx_count;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    uart_rx_mm #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sysclk      (sysclk),
        .nrst        (nrst),
        .uart_rx     (uart_rx),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rx_valid    (rx_valid),
        .rx_count    (rx_count),
        .overrun_err (overrun_err),
        .frame_err   (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .err_clr     (err_clr)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        uart_rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            wait_cyc(CPB);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = par_bit;
        wait_cyc(CPB);
`endif
        uart_rx = stop_bit;
        wait_cyc(CPB);
        uart_rx = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b1, ^d);
        wait_cyc(4);
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
    endtask

    // Monitor: every accepted pop is compared against the expected-byte queue.
    always @(negedge sysclk) begin
        if (nrst && rd_en) begin
            if (exp_q.size() == 0) begin
                check("pop_valid_empty", int'(rx_valid), 0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("pop_valid", int'(rx_valid), 1);
                check("pop_data", int'(rd_data), int'(e));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; uart_rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        wait_cyc(3);
        nrst = 1'b1;
        wait_cyc(2);
        check("rst_valid", int'(rx_valid), 0);
        check("rst_count", int'(rx_count), 0);
        check("rst_data", int'(rd_data), 0);
        check("rst_overrun", int'(overrun_err), 0);
        check("rst_frame", int'(frame_err), 0);

        // Two good bytes, FWFT ordering
        send_ok(8'h55);
        send_ok(8'hA3);
        check("two_count", int'(rx_count), 2);
        check("two_head", int'(rd_data), 8'h55);
        pulse_rd();
        check("one_head", int'(rd_data), 8'hA3);
        check("one_count", int'(rx_count), 1);
        pulse_rd();
        check("drain_valid", int'(rx_valid), 0);
        check("drain_data", int'(rd_data), 0);
        pulse_rd();
        check("underflow_count", int'(rx_count), 0);

        // Stop bit low
        send_frame(8'h3C, 1'b0, ^8'h3C);
        wait_cyc(4);
        check("frame_set", int'(frame_err), 1);
        check("frame_count", int'(rx_count), 0);
        pulse_clr();
        check("frame_clr", int'(frame_err), 0);

        // Overrun: fifth byte dropped
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, ^(8'(i)));
            wait_cyc(4);
        end
        check("ovr_count", int'(rx_count), 4);
        check("ovr_flag", int'(overrun_err), 1);
        check("ovr_head", int'(rd_data), 8'h01);
        for (int i = 0; i < 4; i++) pulse_rd();
        check("ovr_drained", int'(rx_valid), 0);
        pulse_clr();
        check("ovr_clr", int'(overrun_err), 0);

        // Glitch shorter than half a bit
        uart_rx = 1'b0;
        wait_cyc(5);
        uart_rx = 1'b1;
        wait_cyc(40);
        check("glitch_count", int'(rx_count), 0);
        check("glitch_frame", int'(frame_err), 0);
        check("glitch_ovr", int'(overrun_err), 0);
        send_ok(8'h5A);
        check("post_glitch_count", int'(rx_count), 1);
        pulse_rd();

        // Full FIFO with a pop landing exactly on the push cycle
        send_ok(8'h11);
        send_ok(8'h22);
        send_ok(8'h33);
        send_ok(8'h44);
        check("full_count", int'(rx_count), 4);
        exp_q.push_back(8'h66);
        fork
            send_frame(8'h66, 1'b1, ^8'h66);
            begin
                repeat (PUSH_EDGE) @(posedge sysclk);
                #1 rd_en = 1'b1;
                @(posedge sysclk);
                #1 rd_en = 1'b0;
            end
        join
        wait_cyc(4);
        check("simul_count", int'(rx_count), 4);
        check("simul_ovr", int'(overrun_err), 0);
        check("simul_head", int'(rd_data), 8'h22);
        for (int i = 0; i < 4; i++) pulse_rd();
        check("simul_drained", int'(rx_valid), 0);

        // Asynchronous reset in the middle of a 0xFF frame
        uart_rx = 1'b0;
        wait_cyc(CPB);
        uart_rx = 1'b1;
        wait_cyc(40);
        #3 nrst = 1'b0;
        wait_cyc(3);
        nrst = 1'b1;
        wait_cyc(CPB * 8);
        check("rst_mid_count", int'(rx_count), 0);
        send_ok(8'h12);
        check("after_rst_count", int'(rx_count), 1);
        check("after_rst_head", int'(rd_data), 8'h12);
        pulse_rd();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        wait_cyc(4);
        check("par_err_set", int'(parity_err), 1);
        check("par_err_count", int'(rx_count), 0);
        pulse_clr();
        check("par_err_clr", int'(parity_err), 0);
        send_ok(8'h07);
        check("par_ok_count", int'(rx_count), 1);
        pulse_rd();
`endif

        wait_cyc(2);
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
